// File: rtl/dgiota_pkg.sv
// Shared constants, frame field positions and FSM state encoding for the
// dgiota serial configuration loader.
package dgiota_pkg;

    localparam int DGIOTA_NREG = 8;
    localparam int DGIOTA_DW   = 8;

    localparam int FRAME_BITS = 16;
    localparam int HDR_BITS   = 8;
    localparam int W_BIT      = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 12;
    localparam int DATA_MSB   = 7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        DONE,
        ERR
    } state_t;

    // The frame always carries a 3-bit address; only NREG of them exist.
    function automatic logic addr_in_range(input logic [2:0] addr, input int nreg);
        return int'(addr) < nreg;
    endfunction

endpackage

// File: rtl/dgiota_cfg_loader_if.sv
// Pin-level serial bus between the host (ui_in pins) and the config loader.
interface dgiota_cfg_loader_if;

    logic pin_sclk;
    logic pin_sdi;
    logic pin_cs_n;
    logic sdo;
    logic sdo_oe;

    modport master (
        output pin_sclk,
        output pin_sdi,
        output pin_cs_n,
        input  sdo,
        input  sdo_oe
    );

    modport slave (
        input  pin_sclk,
        input  pin_sdi,
        input  pin_cs_n,
        output sdo,
        output sdo_oe
    );

endinterface

// File: rtl/dgiota_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus single-cycle
// rise/fall pulses derived from the synchronised level.
module dgiota_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic                   level;

    assign level = chain[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/dgiota_cfg_loader.sv
// Serial configuration front-end: deserialises 16-bit frames from the pins,
// holds NREG config bytes for the analog core and supports byte readback.
module dgiota_cfg_loader
    import dgiota_pkg::*;
#(
    parameter int NREG        = DGIOTA_NREG,
    parameter int DW          = DGIOTA_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dgiota_cfg_loader_if.slave   bus,
    output logic [NREG*DW-1:0]   cfg,
    output logic                 cfg_update,
    output logic                 frame_err
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = 5;
    localparam logic [CW-1:0] HDR_CNT   = CW'(HDR_BITS);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_chain;
    logic sdi_s;

    dgiota_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.pin_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n idles high, so its synchroniser resets high to avoid a false fall.
    dgiota_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.pin_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the sclk chain so sdi_s is the bit present at the sclk rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sdi_chain <= '0;
        else        sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], bus.pin_sdi};
    end
    assign sdi_s = sdi_chain[SYNC_STAGES-1];

    state_t                state_q, state_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic [FRAME_BITS-1:0] shift_q, shift_n;
    logic                  rd_q, rd_n;
    logic [DW-1:0]         rdsh_q, rdsh_n;
    logic                  cs_active_q, cs_active_n;
    logic                  wr_en, upd_n, err_n;
    logic [DW-1:0]         regs [NREG];
    logic [2:0]            frame_addr, hdr_addr;

    assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
    assign hdr_addr   = shift_n[ADDR_MSB-HDR_BITS:ADDR_LSB-HDR_BITS];

    // NOTE: every signal gets a default before the branches so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        shift_n     = shift_q;
        rd_n        = rd_q;
        rdsh_n      = rdsh_q;
        cs_active_n = cs_active_q;
        wr_en       = 1'b0;
        upd_n       = 1'b0;
        err_n       = 1'b0;

        if (cs_rise) begin
            // Frame end wins over any coincident sclk edge.
            state_n     = IDLE;
            cnt_n       = '0;
            cs_active_n = 1'b0;
            case (state_q)
                DONE: begin
                    if (shift_q[W_BIT]) begin
                        if (addr_in_range(frame_addr, NREG)) begin
                            wr_en = 1'b1;
                            upd_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                CMD, DATA, ERR: begin
                    if (cnt_q != '0) err_n = 1'b1;
                end
                default: ;
            endcase
        end else if (cs_fall) begin
            cs_active_n = 1'b1;
            if (state_q == IDLE) begin
                state_n = CMD;
                cnt_n   = '0;
            end
        end else if (sclk_rise) begin
            case (state_q)
                CMD: begin
                    shift_n = {shift_q[FRAME_BITS-2:0], sdi_s};
                    cnt_n   = cnt_q + 1'b1;
                    if (cnt_n == HDR_CNT) begin
                        state_n = DATA;
                        rd_n    = ~shift_n[W_BIT-HDR_BITS];
                        rdsh_n  = addr_in_range(hdr_addr, NREG) ? regs[hdr_addr[AW-1:0]] : '0;
                    end
                end
                DATA: begin
                    shift_n = {shift_q[FRAME_BITS-2:0], sdi_s};
                    cnt_n   = cnt_q + 1'b1;
                    if (cnt_n == FRAME_CNT) state_n = DONE;
                end
                DONE: begin
                    state_n = ERR;
                    cnt_n   = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end else if (sclk_fall && state_q == DATA && rd_q && cnt_q > HDR_CNT) begin
            // The fall that closes the 8th bit must not shift: the host
            // samples data bit 7 on the 9th rise.
            rdsh_n = {rdsh_q[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rd_q        <= 1'b0;
            rdsh_q      <= '0;
            cs_active_q <= 1'b0;
            cfg_update  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            shift_q     <= shift_n;
            rd_q        <= rd_n;
            rdsh_q      <= rdsh_n;
            cs_active_q <= cs_active_n;
            cfg_update  <= upd_n;
            frame_err   <= err_n;
        end
    end

    // NOTE: the register file is reset explicitly because the analog core
    // sees these bytes directly and must start from a known safe setting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else if (wr_en) begin
            regs[frame_addr[AW-1:0]] <= shift_q[DATA_MSB:0];
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_cfg
        assign cfg[k*DW +: DW] = regs[k];
    end

    assign bus.sdo    = (state_q == DATA && rd_q) ? rdsh_q[DW-1] : 1'b0;
    assign bus.sdo_oe = cs_active_q;

endmodule

// File: tb/tb_dgiota_cfg_loader.sv
// Directed bench for dgiota_cfg_loader: bit-bangs frames on the pins and
// checks cfg, readback and the commit/error pulses against fixed values.
module tb_dgiota_cfg_loader;

    logic        clk;
    logic        rst_n;
    logic [63:0] cfg;
    logic        cfg_update;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int n_upd = 0;
    int n_err = 0;

    dgiota_cfg_loader_if bus ();

    dgiota_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cfg        (cfg),
        .cfg_update (cfg_update),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_update) n_upd++;
        if (frame_err)  n_err++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        bus.pin_sdi = b;
        clks(4);
        s = bus.sdo;
        bus.pin_sclk = 1'b1;
        clks(4);
        bus.pin_sclk = 1'b0;
    endtask

    // Sends nbits MSB-first (bits past 16 are 0), captures sdo on data rises,
    // and reports the pulses seen in the cycle after cs_n rise detection.
    task automatic xfer(input logic [15:0] f, input int nbits,
                        output logic [7:0] rd, output logic upd, output logic err);
        logic s;
        rd = '0;
        bus.pin_cs_n = 1'b0;
        clks(4);
        check("sdo_oe_active", {63'd0, bus.sdo_oe}, 64'd1);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 16) ? f[15-i] : 1'b0, s);
            if (i >= 8 && i < 16) rd[15-i] = s;
        end
        clks(4);
        bus.pin_cs_n = 1'b1;
        clks(2);
        check("no_early_update", {63'd0, cfg_update}, 64'd0);
        clks(1);
        upd = cfg_update;
        err = frame_err;
        clks(2);
    endtask

    initial begin
        logic [7:0] rd;
        logic       upd, err, s;
        int         u0, e0;

        rst_n        = 1'b0;
        bus.pin_sclk = 1'b0;
        bus.pin_sdi  = 1'b0;
        bus.pin_cs_n = 1'b1;
        clks(3);
        check("rst_cfg", cfg, 64'd0);
        check("rst_sdo", {63'd0, bus.sdo}, 64'd0);
        check("rst_sdo_oe", {63'd0, bus.sdo_oe}, 64'd0);
        check("rst_upd", {63'd0, cfg_update}, 64'd0);
        check("rst_err", {63'd0, frame_err}, 64'd0);
        rst_n = 1'b1;
        clks(4);

        xfer(16'hB0A5, 16, rd, upd, err);
        check("w3_upd", {63'd0, upd}, 64'd1);
        check("w3_err", {63'd0, err}, 64'd0);
        check("w3_cfg", cfg, 64'h0000_0000_A500_0000);
        check("w3_upd_count", 64'(n_upd), 64'd1);
        check("idle_sdo_oe", {63'd0, bus.sdo_oe}, 64'd0);

        xfer(16'h3000, 16, rd, upd, err);
        check("r3_data", {56'd0, rd}, 64'hA5);
        check("r3_upd", {63'd0, upd}, 64'd0);
        check("r3_err", {63'd0, err}, 64'd0);
        check("r3_cfg", cfg, 64'h0000_0000_A500_0000);
        check("r3_upd_count", 64'(n_upd), 64'd1);

        xfer(16'h8FFF, 16, rd, upd, err);
        check("w0_upd", {63'd0, upd}, 64'd1);
        xfer(16'hF081, 16, rd, upd, err);
        check("w7_upd", {63'd0, upd}, 64'd1);
        check("w0w7_cfg", cfg, 64'h8100_0000_A500_00FF);

        u0 = n_upd;
        e0 = n_err;
        xfer(16'h8000, 12, rd, upd, err);
        check("short_err", {63'd0, err}, 64'd1);
        check("short_upd", {63'd0, upd}, 64'd0);
        xfer(16'h8000, 17, rd, upd, err);
        check("long_err", {63'd0, err}, 64'd1);
        check("long_upd", {63'd0, upd}, 64'd0);
        check("bad_frames_cfg", cfg, 64'h8100_0000_A500_00FF);
        check("bad_frames_err_count", 64'(n_err - e0), 64'd2);
        check("bad_frames_upd_count", 64'(n_upd - u0), 64'd0);

        e0 = n_err;
        xfer(16'h0000, 0, rd, upd, err);
        check("empty_err", {63'd0, err}, 64'd0);
        check("empty_upd", {63'd0, upd}, 64'd0);
        check("empty_err_count", 64'(n_err - e0), 64'd0);

        bus.pin_cs_n = 1'b0;
        clks(4);
        for (int i = 0; i < 10; i++) begin
            logic [15:0] fr;
            fr = 16'h9C33;
            send_bit(fr[15-i], s);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cfg", cfg, 64'd0);
        check("midrst_sdo_oe", {63'd0, bus.sdo_oe}, 64'd0);
        check("midrst_sdo", {63'd0, bus.sdo}, 64'd0);
        check("midrst_upd", {63'd0, cfg_update}, 64'd0);
        check("midrst_err", {63'd0, frame_err}, 64'd0);
        bus.pin_cs_n = 1'b1;
        bus.pin_sclk = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        check("post_rst_cfg", cfg, 64'd0);

        xfer(16'hE042, 16, rd, upd, err);
        check("w6_upd", {63'd0, upd}, 64'd1);
        check("w6_cfg", cfg, 64'h0042_0000_0000_0000);
        xfer(16'h6000, 16, rd, upd, err);
        check("r6_data", {56'd0, rd}, 64'h42);
        check("r6_upd", {63'd0, upd}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
